// File: rtl/mb32_pkg.sv
// Shared constants and result record for the mb32 multiplier and its consumers.
package mb32_pkg;

  localparam int WIDTH    = 32;          // multiplier operand width
  localparam int PWIDTH   = 2 * WIDTH;   // product width
  localparam int MB32_LAT = 4;           // mb32_top product latency in clock cycles

  // The result record is sized for the widest legal build. Each stage
  // zero-extends into it and slices its own widths back out.
  localparam int SUM_MAXW = PWIDTH + 32;
  localparam int CNT_MAXW = 32;

  typedef struct packed {
    logic [SUM_MAXW-1:0] sum;
    logic [CNT_MAXW-1:0] cnt;
    logic                ovf;
  } mb32_res_t;

endpackage

// File: rtl/mb32_res_fifo.sv
// Small register FIFO of group results with wrap-around pointers.
module mb32_res_fifo
  import mb32_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  mb32_res_t     wdata,
  input  logic          pop,
  output mb32_res_t     rdata,
  output logic [CW-1:0] count,
  output logic          empty
);

  mb32_res_t      mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_pop;
  logic           full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop & ~empty;
  assign rdata  = mem[rd_ptr];

  // Storage, pointers and occupancy; push and pop together keep the count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The upstream credit scheme reserves a slot for every group in flight.
  a_no_overflow: assert property (@(posedge CLK) disable iff (RST) !(push && full));

endmodule

// File: rtl/mb32_acc_stage.sv
// Accumulates mb32_top products into one unsigned sum per group and hands
// each finished group out through a small result FIFO.
//
// Handshakes: a term transfers on a rising CLK edge where in_valid & in_ready;
// a result transfers on a rising edge where out_valid & out_ready. Once valid
// is raised the sender holds its payload stable until the transfer.
module mb32_acc_stage
  import mb32_pkg::*;
#(
  parameter int ACCW  = 80,        // accumulator width, PWIDTH..PWIDTH+32
  parameter int CNTW  = 16,        // term-counter width, at most 32
  parameter int LAT   = MB32_LAT,  // product latency of mb32_top, >= 1
  parameter int DEPTH = 2          // result FIFO depth, >= 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [PWIDTH-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACCW-1:0]   out_sum,
  output logic [CNTW-1:0]   out_cnt,
  output logic              out_ovf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = ACCW + 1;

  logic            acc_term;
  logic [LAT-1:0]  tag_vld;
  logic [LAT-1:0]  tag_last;
  logic            t_vld;
  logic            t_last;
  logic [31:0]     last_inflight;

  logic [ACCW-1:0] acc_sum;
  logic [CNTW-1:0] acc_cnt;
  logic            acc_ovf;
  logic            first;

  logic [SW-1:0]   sum_wide;
  logic [ACCW-1:0] nxt_sum;
  logic [CNTW-1:0] nxt_cnt;
  logic            nxt_ovf;
  logic            cnt_sat;

  logic            push;
  mb32_res_t       push_res;
  mb32_res_t       head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            unused_head;

  assign acc_term = in_valid & in_ready;
  assign t_vld    = tag_vld[LAT-1];
  assign t_last   = tag_last[LAT-1];

  // Tag delay line: the tail lines up with the product of the same operand pair.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_vld  <= '0;
      tag_last <= '0;
    end else begin
      tag_vld[0]  <= acc_term;
      tag_last[0] <= in_last & acc_term;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_last[i] <= tag_last[i-1];
      end
    end
  end

  // Groups already closed but still travelling through the multiplier.
  always_comb begin
    last_inflight = '0;
    for (int i = 0; i < LAT; i++) last_inflight = last_inflight + 32'(tag_last[i]);
  end

  // Every closed group owns a FIFO slot, so nothing that leaves the multiplier
  // can find the FIFO full.
  assign in_ready = (32'(fifo_count) + last_inflight) < 32'(DEPTH);

  // Next accumulator state for the product at the tail of the delay line.
  always_comb begin
    sum_wide = {1'b0, acc_sum} + SW'(product);
    cnt_sat  = &acc_cnt;
    nxt_sum  = acc_sum;
    nxt_cnt  = acc_cnt;
    nxt_ovf  = acc_ovf;
    if (first) begin
      nxt_sum = ACCW'(product);
      nxt_cnt = CNTW'(1);
      nxt_ovf = 1'b0;
    end else begin
      nxt_sum = sum_wide[ACCW-1:0];
      nxt_cnt = cnt_sat ? acc_cnt : acc_cnt + CNTW'(1);
      nxt_ovf = acc_ovf | sum_wide[ACCW] | cnt_sat;
    end
  end

  // Accumulator registers; a closing term re-arms the first flag so the next
  // valid product starts a fresh group with no bubble.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_sum <= '0;
      acc_cnt <= '0;
      acc_ovf <= 1'b0;
      first   <= 1'b1;
    end else if (t_vld) begin
      acc_sum <= nxt_sum;
      acc_cnt <= nxt_cnt;
      acc_ovf <= nxt_ovf;
      first   <= t_last;
    end
  end

  assign push         = t_vld & t_last;
  assign push_res.sum = SUM_MAXW'(nxt_sum);
  assign push_res.cnt = CNT_MAXW'(nxt_cnt);
  assign push_res.ovf = nxt_ovf;

  mb32_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .wdata (push_res),
    .pop   (out_ready),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_sum   = head.sum[ACCW-1:0];
  assign out_cnt   = head.cnt[CNTW-1:0];
  assign out_ovf   = head.ovf;

  // Padding bits of the shared record beyond this build's widths.
  assign unused_head = ^head;

endmodule

// File: tb/tb_mb32_acc_stage.sv
// Bench for mb32_acc_stage: a behavioural multiplier pipeline feeds products,
// a group-level model predicts each result, a scoreboard checks them in order.
module tb_mb32_acc_stage;
  import mb32_pkg::*;

  localparam int ACCW  = 80;
  localparam int CNTW  = 16;
  localparam int LAT   = MB32_LAT;
  localparam int DEPTH = 2;
  localparam int EW    = 1 + CNTW + ACCW;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  // ---------------- DUT signals ----------------
  logic              in_valid, in_last, in_ready, out_valid, out_ready, out_ovf;
  logic [WIDTH-1:0]  mx, my;
  logic [PWIDTH-1:0] product;
  logic [ACCW-1:0]   out_sum;
  logic [CNTW-1:0]   out_cnt;

  logic              r64_in_ready, r64_out_valid, r64_out_ovf;
  logic [63:0]       r64_out_sum;
  logic [CNTW-1:0]   r64_out_cnt;

  // Multiplier stand-in: computes every cycle, idle cycles included.
  logic [PWIDTH-1:0] mul_pipe [LAT];
  always @(posedge CLK) begin
    mul_pipe[0] <= PWIDTH'(mx) * PWIDTH'(my);
    for (int i = 1; i < LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign product = mul_pipe[LAT-1];

  mb32_acc_stage #(.ACCW(ACCW), .CNTW(CNTW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .product(product), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  // Narrow-accumulator build sharing the same stream, used for the wrap case.
  mb32_acc_stage #(.ACCW(64), .CNTW(CNTW), .LAT(LAT), .DEPTH(DEPTH)) dut64 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_last(in_last), .in_ready(r64_in_ready),
    .product(product), .out_valid(r64_out_valid), .out_ready(out_ready),
    .out_sum(r64_out_sum), .out_cnt(r64_out_cnt), .out_ovf(r64_out_ovf)
  );

  // ---------------- model / scoreboard state ----------------
  logic [127:0]   m_sum;
  int unsigned    m_cnt;
  logic [EW-1:0]  exp_q[$];
  int             n_vec, n_err;
  bit             rand_ready;

  function automatic void model_clear();
    m_sum = '0;
    m_cnt = 0;
  endfunction

  function automatic void model_accept(input logic [31:0] x, input logic [31:0] y, input logic last);
    logic [CNTW-1:0] c;
    logic            o;
    m_sum = m_sum + 128'(x) * 128'(y);
    m_cnt = m_cnt + 1;
    if (last) begin
      o = ((m_sum >> ACCW) != 0) || (m_cnt > 65535);
      c = (m_cnt > 65535) ? 16'hFFFF : CNTW'(m_cnt);
      exp_q.push_back({o, c, m_sum[ACCW-1:0]});
      model_clear();
    end
  endfunction

  // Scoreboard: every delivered result must be the oldest expected one.
  task automatic mon_step();
    logic [EW-1:0] e;
    @(negedge CLK);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got sum=%0h cnt=%0d ovf=%0b, required no result",
                 out_sum, out_cnt, out_ovf);
      end else begin
        e = exp_q.pop_front();
        if ({out_ovf, out_cnt, out_sum} !== e) begin
          n_err++;
          $display("FAIL result: got sum=%0h cnt=%0d ovf=%0b, required sum=%0h cnt=%0d ovf=%0b",
                   out_sum, out_cnt, out_ovf, e[ACCW-1:0], e[ACCW+CNTW-1:ACCW], e[EW-1]);
        end
      end
    end
  endtask

  // ---------------- driver tasks (entered just after a rising edge) ----------------
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic last);
    bit ok;
    bit done;
    int waited;
    mx = x; my = y; in_valid = 1'b1; in_last = last;
    done = 0;
    waited = 0;
    while (!done) begin
      @(negedge CLK);
      ok = (in_ready === 1'b1);
      @(posedge CLK);
      if (ok) begin
        model_accept(x, y, last);
        done = 1;
      end else begin
        waited++;
        if (waited > 500) begin
          n_vec++;
          n_err++;
          $display("FAIL send_timeout: got in_ready low for %0d cycles, required acceptance", waited);
          done = 1;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      mx = $urandom; my = $urandom; in_last = 1'($urandom_range(0, 1));
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_clear();
    exp_q.delete();
  endtask

  task automatic wait_out(output bit seen);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK);
      if (out_valid === 1'b1) seen = 1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge CLK);
    repeat (LAT + 4) @(posedge CLK);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_vec++; if (out_sum !== '0)     begin n_err++; $display("FAIL reset_out_sum: got %0h required 0", out_sum); end
    n_vec++; if (out_cnt !== '0)     begin n_err++; $display("FAIL reset_out_cnt: got %0d required 0", out_cnt); end
    n_vec++; if (out_ovf !== 1'b0)   begin n_err++; $display("FAIL reset_out_ovf: got %b required 0", out_ovf); end
    @(posedge CLK); #1;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send(32'd3, 32'd5, 1'b1);
    in_valid = 1'b0;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge CLK);
      n_vec++;
      if (out_valid !== (c == LAT + 1)) begin
        n_err++;
        $display("FAIL single_timing: cycle %0d got out_valid=%b required %b", c, out_valid, (c == LAT + 1));
      end
    end
    @(posedge CLK); #1;
    drain();
  endtask

  task automatic test_back_to_back();
    bit seen;
    out_ready = 1'b1;
    send(32'd1, 32'd2, 1'b0);
    send(32'd3, 32'd4, 1'b0);
    send(32'd5, 32'd6, 1'b0);
    send(32'd7, 32'd8, 1'b1);
    send(32'd2, 32'd2, 1'b1);
    in_valid = 1'b0;
    wait_out(seen);
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL b2b_first: got no out_valid, required a result"); end
    @(negedge CLK);
    n_vec++;
    if (out_valid !== 1'b1 || out_sum !== 80'd4) begin
      n_err++;
      $display("FAIL b2b_second: got valid=%b sum=%0h, required valid=1 sum=4 next cycle", out_valid, out_sum);
    end
    @(posedge CLK); #1;
    drain();
  endtask

  task automatic test_wrap64();
    bit seen;
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(32'd1, 32'd1, 1'b1);
    in_valid = 1'b0;
    wait_out(seen);
    n_vec++;
    if (!seen || r64_out_valid !== 1'b1 || r64_out_sum !== 64'hFFFF_FFFC_0000_0002 ||
        r64_out_cnt !== 16'd2 || r64_out_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL wrap64: got valid=%b sum=%0h cnt=%0d ovf=%b, required 1 fffffffc00000002 2 1",
               r64_out_valid, r64_out_sum, r64_out_cnt, r64_out_ovf);
    end
    @(negedge CLK);
    n_vec++;
    if (r64_out_valid !== 1'b1 || r64_out_sum !== 64'd1 || r64_out_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL wrap64_next: got valid=%b sum=%0h ovf=%b, required 1 1 0",
               r64_out_valid, r64_out_sum, r64_out_ovf);
    end
    @(posedge CLK); #1;
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(32'd1, 32'd1, 1'b1);
    send(32'd2, 32'd2, 1'b1);
    mx = 32'd3; my = 32'd3; in_valid = 1'b1; in_last = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL credit_stall: cycle %0d got in_ready=%b required 0", c, in_ready);
      end
    end
    @(posedge CLK); #1;
    out_ready = 1'b1;
    send(32'd3, 32'd3, 1'b1);
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(32'd1, 32'd2, 1'b0);
    send(32'd3, 32'd4, 1'b0);
    in_valid = 1'b0;
    RST = 1'b1;
    model_clear();
    exp_q.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid_valid: got %b required 0", out_valid); end
    @(posedge CLK); #1;
    send(32'd6, 32'd7, 1'b1);
    idle(1);
    drain();
  endtask

  task automatic test_random();
    rand_ready = 1;
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send($urandom, $urandom, ($urandom_range(0, 3) == 0) || (t == 599));
    end
    idle(1);
    rand_ready = 0;
    out_ready = 1'b1;
    drain();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_vec = 0; n_err = 0; rand_ready = 0;
    RST = 1'b1; in_valid = 1'b0; in_last = 1'b0; mx = '0; my = '0; out_ready = 1'b0;
    model_clear();
    fork
      forever mon_step();
      forever begin
        @(posedge CLK);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap64();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
